// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM state encodings and register constants.
// Pure definitions; no logic, so no latency or backpressure of its own.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BR_LD2 = 2'd1,
    FREEZE = 2'd2
  } hazState_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // $zero is never a real producer, so it must never cause a stall.
  function automatic logic srcHit(input logic [4:0] exRd,
                                  input logic [4:0] idRs,
                                  input logic [4:0] idRt,
                                  input logic       usesRt);
    return (exRd != REG_ZERO) && ((exRd == idRs) || (usesRt && (exRd == idRt)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: adds one per cycle with inc high, sticks at all-ones.
// One-cycle latency from inc to cnt; no backpressure.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Per-cycle pipeline-register control for the 5-stage core: load-use / branch-compare
// stalls, taken-branch flushes, cache-miss freezes. Outputs are same-cycle combinational.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IfIdRs,
  input  logic [4:0]       IfIdRt,
  input  logic             IfIdUsesRt,
  input  logic             IdIsBranch,
  input  logic             IdBranchTaken,
  input  logic             IdJump,
  input  logic             IdExMemRead,
  input  logic             IdExRegW,
  input  logic [4:0]       IdExRd,
  input  logic             ICacheStall,
  input  logic             DCacheStall,
  output logic             PcWrite,
  output logic             IfIdWrite,
  output logic             IfIdFlush,
  output logic             IdExWrite,
  output logic             IdExBubble,
  output logic             ExMemWrite,
  output logic             MemWbWrite,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  hazState_t stateQ, stateD;
  hazState_t retQ, retD;
  hazState_t effState;
  logic      memStall;
  logic      hit;
  logic      loadUse;
  logic      brDep;

  assign memStall = ICacheStall | DCacheStall;
  assign hit      = srcHit(IdExRd, IfIdRs, IfIdRt, IfIdUsesRt);
  assign loadUse  = IdExMemRead & hit;
  assign brDep    = IdIsBranch & IdExRegW & hit;

  // Leaving a freeze replays the interrupted state, so a pending BR_LD2 bubble is not lost.
  assign effState = (stateQ == FREEZE) ? retQ : stateQ;

  always_comb begin
    PcWrite    = 1'b0;
    IfIdWrite  = 1'b0;
    IfIdFlush  = 1'b0;
    IdExWrite  = 1'b0;
    IdExBubble = 1'b0;
    ExMemWrite = 1'b0;
    MemWbWrite = 1'b0;
    stateD     = stateQ;
    retD       = retQ;

    if (rst) begin
      stateD = RUN;
      retD   = RUN;
    end else if (memStall) begin
      if (stateQ != FREEZE) begin
        stateD = FREEZE;
        retD   = stateQ;
      end
    end else if (effState == BR_LD2) begin
      IdExWrite  = 1'b1;
      IdExBubble = 1'b1;
      ExMemWrite = 1'b1;
      MemWbWrite = 1'b1;
      stateD     = RUN;
    end else if (loadUse || brDep) begin
      IdExWrite  = 1'b1;
      IdExBubble = 1'b1;
      ExMemWrite = 1'b1;
      MemWbWrite = 1'b1;
      // A branch behind a load waits for the load to reach MEM/WB: two bubbles.
      stateD     = (loadUse && IdIsBranch) ? BR_LD2 : RUN;
    end else begin
      PcWrite    = 1'b1;
      IfIdWrite  = 1'b1;
      IdExWrite  = 1'b1;
      ExMemWrite = 1'b1;
      MemWbWrite = 1'b1;
      IfIdFlush  = IdJump | (IdIsBranch & IdBranchTaken);
      stateD     = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= RUN;
      retQ   <= RUN;
    end else begin
      stateQ <= stateD;
      retQ   <= retD;
    end
  end

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk (clk),
    .rst (rst),
    .inc (!PcWrite),
    .cnt (StallCnt)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk (clk),
    .rst (rst),
    .inc (IfIdFlush),
    .cnt (FlushCnt)
  );

endmodule
